// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one serial adder between NREQ requesters.
// One operation is in flight at a time. The sum is returned tagged with the
// requester index over a valid/ready result port.
module serial_add_sched #(
    parameter int SIZE = 8,
    parameter int NREQ = 4,
    parameter int LAT  = 10,
    parameter int IDW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*SIZE-1:0] A_IN,
    input  logic [NREQ*SIZE-1:0] B_IN,
    output logic [NREQ-1:0]      GNT,
    output logic                 ADD_START,
    output logic [SIZE-1:0]      ADD_A,
    output logic [SIZE-1:0]      ADD_B,
    input  logic [SIZE:0]        ADD_SUM,
    output logic                 RES_VALID,
    output logic [IDW-1:0]       RES_ID,
    output logic [SIZE:0]        RES_SUM,
    input  logic                 RES_READY,
    output logic                 BUSY
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  sel_hi;
    logic [IDW-1:0]  sel_lo;
    logic            found_hi;
    logic            found_lo;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic            cnt_done;

    // Round-robin pick: first request at or above ptr, else the lowest request
    // overall (which must then lie below ptr), giving the rotating search order.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (REQ[j]) begin
                if (!found_hi && (j >= 32'(ptr))) begin
                    found_hi = 1'b1;
                    sel_hi   = IDW'(j);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    sel_lo   = IDW'(j);
                end
            end
        end
        sel     = found_hi ? sel_hi : sel_lo;
        ptr_nxt = (32'(sel) == 32'(NREQ - 1)) ? '0 : sel + IDW'(1);
    end

    // Operand slice of the selected requester.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IDW'(j) == sel) begin
                op_a = A_IN[j*SIZE +: SIZE];
                op_b = B_IN[j*SIZE +: SIZE];
            end
        end
    end

    assign cnt_done = (cnt == CW'(LAT));

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe outputs; GNT is gated by RST so no grant leaks during reset.
    always_comb begin
        state_nxt = state;
        GNT       = '0;
        ADD_START = 1'b0;
        RES_VALID = 1'b0;
        BUSY      = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (found_lo && RST) begin
                    GNT       = NREQ'(1) << sel;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                ADD_START = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cnt_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                RES_VALID = 1'b1;
                if (RES_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: operand capture at grant, latency count, sum capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr     <= '0;
            cnt     <= '0;
            ADD_A   <= '0;
            ADD_B   <= '0;
            RES_ID  <= '0;
            RES_SUM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_lo) begin
                        ADD_A  <= op_a;
                        ADD_B  <= op_b;
                        RES_ID <= sel;
                        ptr    <= ptr_nxt;
                    end
                end
                LAUNCH: begin
                    cnt <= CW'(1);
                end
                RUN: begin
                    if (cnt_done) begin
                        RES_SUM <= ADD_SUM;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Round-robin scheduler that shares one serial adder datapath between NREQ requesters.
- Accepts operand pairs from requesters and sequences the adder's START pulse and latency window.
- Captures the (SIZE+1)-bit sum and returns it, tagged with the requester ID, over a valid/ready result port.
- Sits between client blocks and the single serial adder instance; one operation in flight at a time.

Parameters:
SIZE, 8, operand width; sum is SIZE+1 bits
NREQ, 4, number of requesters (legal 2..8)
LAT, 10, cycles from the ADD_START cycle to the cycle ADD_SUM is valid (adder contract, >=1; SIZE+2 for the 8-bit adder)
IDW, 2, requester ID width, >= clog2(NREQ)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
REQ  input  NREQ  per-requester request; held until its GNT
A_IN  input  NREQ*SIZE  packed operand A, requester i at [i*SIZE +: SIZE]
B_IN  input  NREQ*SIZE  packed operand B, same packing
GNT  output  NREQ  one-hot, one-cycle pulse; operands of that requester captured this cycle
ADD_START  output  1  one-cycle start pulse to adder
ADD_A  output  SIZE  operand A to adder, stable from ADD_START until capture
ADD_B  output  SIZE  operand B to adder, same
ADD_SUM  input  SIZE+1  adder result, sampled exactly LAT cycles after ADD_START
RES_VALID  output  1  result available
RES_ID  output  IDW  requester index of result
RES_SUM  output  SIZE+1  captured sum
RES_READY  input  1  consumer accepts result when RES_VALID&&RES_READY
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST low, async):
  - State IDLE; priority pointer PTR=0; counter 0.
  - GNT, ADD_START, RES_VALID, BUSY = 0.
  - ADD_A, ADD_B, RES_SUM, RES_ID = 0.
- Reset mid-operation aborts the operation with no result and no partial GNT. The adder shares RST.
- States: IDLE -> LAUNCH -> RUN -> HOLD -> IDLE.
- IDLE:
  - If any REQ is high, select the first set bit searching PTR, PTR+1, ... mod NREQ.
  - Assert GNT[sel] for that cycle only. Latch A_IN/B_IN slice into ADD_A/ADD_B, latch sel into RES_ID.
  - Set PTR = (sel+1) mod NREQ. Go to LAUNCH.
  - If no REQ is high, stay in IDLE.
- LAUNCH: ADD_START=1 for exactly this cycle (cycle t); counter=1; go to RUN.
- RUN:
  - Counter increments each cycle.
  - In cycle t+LAT (counter==LAT), capture ADD_SUM into RES_SUM and go to HOLD.
  - ADD_A/ADD_B do not change in RUN.
- HOLD:
  - RES_VALID=1; RES_SUM and RES_ID stable.
  - On RES_VALID&&RES_READY, clear RES_VALID next cycle and go to IDLE.
  - No GNT is issued in HOLD, even if REQ is pending.
- Timing from GNT at cycle g:
  - ADD_START at g+1; capture at g+1+LAT; RES_VALID from g+2+LAT.
  - With RES_READY tied high: accept at g+2+LAT, earliest next GNT at g+3+LAT.
  - Throughput is one operation per LAT+3 cycles.
- REQ dropped before GNT: no grant; the pointer is unchanged. Requests are not sticky.
- A REQ bit of a granted requester may stay high. It is re-arbitrated next IDLE with its priority now lowest.
- Sum is the raw ADD_SUM (SIZE+1 bits, carry in MSB). No truncation or sign handling.
- Counter width clog2(LAT+1); it never wraps within one operation.

Test Plan:
- Single request: REQ=0010, A=8'h3C, B=8'h05 -> GNT=0010 for 1 cycle; ADD_START one cycle later; RES_VALID at g+12 with RES_SUM=9'h041, RES_ID=1.
- All four requesting at once, RES_READY=1, operands (i,i) for i=0..3 -> grants in order 0,1,2,3, spaced 13 cycles; results 0,2,4,6 with matching IDs.
- Fairness: REQ0 and REQ2 held continuously -> grants alternate 0,2,0,2; REQ0 never granted twice in a row.
- Backpressure: RES_READY low for 5 cycles after RES_VALID, REQ3 pending -> RES_SUM/RES_ID stable, no GNT, BUSY=1; GNT3 one cycle after the accepting cycle.
- Carry/max: A=8'hFF, B=8'hFF -> RES_SUM=9'h1FE; A=8'h80, B=8'h80 -> RES_SUM=9'h100.
- Reset in RUN (RST low at g+5) -> all outputs 0 immediately and PTR=0. After release, REQ=1000 gets GNT=1000 one cycle later and completes correctly.
